// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit hex display scanner with frame-synchronous value
// updates, per-digit enables, leading-zero blanking and anti-ghost blanking.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [7:0]  anodes,
  output logic [3:0]  hex_out,
  output logic        load_ack,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   disp_q, disp_d;
  logic [31:0]   stage_q, stage_d;
  logic          pend_q, pend_d;
  logic [7:0]    en_q;
  logic          lz_q;

  logic          slot_wrap;
  logic          frame_end;
  logic [7:0]    nz_mask;
  logic          lz_blanked;
  logic          visible;

  assign slot_wrap = (cnt_q == CNT_LAST);
  assign frame_end = slot_wrap && (idx_q == 3'd7);

  always_comb begin
    cnt_d   = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d   = slot_wrap ? idx_q + 3'd1 : idx_q;
    disp_d  = disp_q;
    stage_d = stage_q;
    pend_d  = pend_q;
    if (frame_end) begin
      // A load landing on the boundary bypasses staging and shows next frame.
      if (load)        disp_d = value_in;
      else if (pend_q) disp_d = stage_q;
      pend_d = 1'b0;
    end else if (load) begin
      stage_d = value_in;
      pend_d  = 1'b1;
    end
  end

  // NOTE: reset is asynchronous, so clearing cnt/display forces anodes to FF
  // and hex_out to 0 the instant reset rises, without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      stage_q <= '0;
      pend_q  <= 1'b0;
      en_q    <= '0;
      lz_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      stage_q <= stage_d;
      pend_q  <= pend_d;
      en_q    <= digit_en;
      lz_q    <= lz_blank;
    end
  end

  // Digit i is leading-zero blanked when no nonzero nibble exists at i or above.
  always_comb begin
    for (int i = 0; i < 8; i++) nz_mask[i] = |disp_q[4*i +: 4];
  end

  assign lz_blanked = lz_q && (idx_q != 3'd0) && ((nz_mask >> idx_q) == 8'h00);
  assign visible    = en_q[idx_q] && !lz_blanked;

  // NOTE: every output of this block gets its default first, so no latch forms.
  always_comb begin
    anodes = 8'hFF;
    if ((cnt_q >= BLANK_END) && visible) anodes = ~(8'h01 << idx_q);
  end

  assign hex_out    = disp_q[{idx_q, 2'b00} +: 4];
  assign frame_tick = frame_end;
  assign load_ack   = frame_end && (pend_q || load);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a reference model feeding a
// per-cycle scoreboard of expected anodes/hex_out/load_ack/frame_tick.
module tb_display_scan_ctrl;

  localparam int RD = 4;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value_in;
  logic        load;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic [7:0]  anodes;
  logic [3:0]  hex_out;
  logic        load_ack;
  logic        frame_tick;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .load       (load),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .anodes     (anodes),
    .hex_out    (hex_out),
    .load_ack   (load_ack),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [3:0] hx;
    logic       ack;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ack_seen = 0;

  // Reference model state (what the display should hold before the next edge)
  int          cyc;
  logic [31:0] m_disp, m_stage;
  logic        m_pend;
  logic [7:0]  m_en;
  logic        m_lz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_disp = '0; m_stage = '0; m_pend = 1'b0; m_en = '0; m_lz = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_anodes"}, 32'(anodes), 32'h0000_00FF);
    check({tag, "_hex"},    32'(hex_out), 32'h0);
    check({tag, "_ack"},    32'(load_ack), 32'h0);
    check({tag, "_tick"},   32'(frame_tick), 32'h0);
  endtask

  // Called at a falling edge: drive, predict, compare, advance the model.
  task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] en, input logic lz);
    exp_t       e;
    int         slot, c;
    logic       frame, blk;
    logic [7:0] one;
    load = ld; value_in = v; digit_en = en; lz_blank = lz;
    slot  = (cyc / RD) % 8;
    c     = cyc % RD;
    frame = (c == RD - 1) && (slot == 7);
    blk   = m_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 32'h0);
    one   = 8'h01;
    e.an   = (c >= BL && m_en[slot] && !blk) ? ~(one << slot) : 8'hFF;
    e.hx   = m_disp[4*slot +: 4];
    e.ack  = frame && (m_pend || ld);
    e.tick = frame;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check("anodes",     32'(anodes),     32'(e.an));
    check("hex_out",    32'(hex_out),    32'(e.hx));
    check("load_ack",   32'(load_ack),   32'(e.ack));
    check("frame_tick", 32'(frame_tick), 32'(e.tick));
    if (load_ack === 1'b1) ack_seen++;
    if (frame) begin
      if (ld)          m_disp = v;
      else if (m_pend) m_disp = m_stage;
      m_pend = 1'b0;
    end else if (ld) begin
      m_stage = v;
      m_pend  = 1'b1;
    end
    m_en = en;
    m_lz = lz;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; value_in = '0; load = 1'b0; digit_en = 8'hFF; lz_blank = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;

    // Scan order and blanking, load at cycle 5 shown from next frame
    for (int k = 0; k < 64; k++) step(k == 5, 32'h1234_5678, 8'hFF, 1'b0);

    // Two loads in one frame: last wins, single acknowledge
    ack_seen = 0;
    for (int k = 64; k < 96; k++)
      step(k == 67 || k == 74, (k == 67) ? 32'h1 : 32'h2, 8'hFF, 1'b0);
    check("single_ack_count", 32'(ack_seen), 32'd1);

    // Load 0xA00, then show it with leading-zero blanking enabled
    for (int k = 96; k < 128; k++) step(k == 100, 32'h0000_0A00, 8'hFF, k >= 127);
    for (int k = 128; k < 160; k++) step(1'b0, 32'h0, 8'hFF, 1'b1);

    // Only digit 0 enabled; load coincident with the frame boundary
    ack_seen = 0;
    for (int k = 160; k < 192; k++) step(k == 191, 32'h0000_CAFE, 8'h01, 1'b0);
    check("boundary_ack_count", 32'(ack_seen), 32'd1);
    for (int k = 192; k < 224; k++) step(1'b0, 32'h0, 8'hFF, 1'b0);

    // Reset with a value pending: staged value discarded, no ack afterward
    reset = 1'b1;
    #1 check_reset_outputs("reset_assert");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 12; k++) step(k == 8, 32'hFFFF_FFFF, 8'hFF, 1'b0);
    load = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_midcycle");
    @(negedge clk);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    model_reset();
    ack_seen = 0;
    for (int k = 0; k < 64; k++) step(1'b0, 32'h0, 8'hFF, 1'b0);
    check("no_ack_after_reset", 32'(ack_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
